// File: rtl/counter_pkg.sv
// rtl/counter_pkg.sv - shared constants and helpers for the parametrised up/down counter
// Contents:
//   DIR_UP / DIR_DOWN   : encodings of the up_down input
//   MODE_WRAP / MODE_SAT: encodings of the SATURATE parameter
//   clog2()             : ceiling log2, used for parameter sanity checks
package counter_pkg;

  localparam logic DIR_UP   = 1'b1;
  localparam logic DIR_DOWN = 1'b0;

  localparam int MODE_WRAP = 0;
  localparam int MODE_SAT  = 1;

  // Number of bits needed to represent values 0..value-1.
  function automatic int clog2(input int value);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if (((value - 1) >> i) > 0) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/up_down_next.sv
// rtl/up_down_next.sv - combinational next-count and boundary detection
// Ports:
//   cur      (in,  WIDTH) : current count
//   up_down  (in,  1)     : 1 = up, 0 = down
//   nxt      (out, WIDTH) : count after one enabled step
//   boundary (out, 1)     : the step would cross 0 / MAX_VAL (wrap or clamp)
module up_down_next #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic [WIDTH-1:0] cur,
  input  logic             up_down,
  output logic [WIDTH-1:0] nxt,
  output logic             boundary
);
  import counter_pkg::*;

  localparam logic [WIDTH-1:0] MAX_N   = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] STEP_N  = WIDTH'(STEP);
  // MAX_VAL+1 may equal 2**WIDTH and truncate to 0; the wrapped results
  // always land inside 0..MAX_VAL, so modulo-2**WIDTH arithmetic is exact.
  localparam logic [WIDTH-1:0] RANGE_N = WIDTH'(MAX_VAL + 1);

  logic [WIDTH:0]   up_sum;
  logic             up_over;
  logic             dn_under;
  logic [WIDTH-1:0] up_wrap;
  logic [WIDTH-1:0] dn_diff;
  logic [WIDTH-1:0] dn_wrap;

  // The up sum carries one extra bit so out+STEP never overflows the compare.
  assign up_sum   = {1'b0, cur} + {1'b0, STEP_N};
  assign up_over  = up_sum > {1'b0, MAX_N};
  assign dn_under = cur < STEP_N;
  assign up_wrap  = cur + STEP_N - RANGE_N;
  assign dn_diff  = cur - STEP_N;
  assign dn_wrap  = cur + RANGE_N - STEP_N;

  always_comb begin
    nxt      = cur;
    boundary = 1'b0;
    if (up_down == DIR_UP) begin
      boundary = up_over;
      if (!up_over)                 nxt = up_sum[WIDTH-1:0];
      else if (SATURATE == MODE_SAT) nxt = MAX_N;
      else                          nxt = up_wrap;
    end else begin
      boundary = dn_under;
      if (!dn_under)                nxt = dn_diff;
      else if (SATURATE == MODE_SAT) nxt = '0;
      else                          nxt = dn_wrap;
    end
  end

endmodule

// File: rtl/up_down_counter_param.sv
// rtl/up_down_counter_param.sv - parametrised up/down counter with load, enable and boundary flags
// Optional feature macro: COUNTER_OVF_STICKY_EN (adds clr_ovf / ovf_sticky).
// Ports:
//   clk        (in,  1)     : rising-edge clock
//   reset      (in,  1)     : synchronous active-low reset
//   en         (in,  1)     : count enable
//   up_down    (in,  1)     : 1 = up, 0 = down
//   load       (in,  1)     : synchronous load, higher priority than en
//   data       (in,  WIDTH) : load value, clamped to MAX_VAL
//   out        (out, WIDTH) : registered count
//   tc         (out, 1)     : combinational terminal count for current direction
//   wrap       (out, 1)     : registered one-cycle boundary-event pulse
//   clr_ovf    (in,  1)     : clears ovf_sticky (macro builds only)
//   ovf_sticky (out, 1)     : sticky boundary-event flag (macro builds only)
module up_down_counter_param #(
  parameter int WIDTH    = 4,
  parameter int MAX_VAL  = (1 << WIDTH) - 1,
  parameter int STEP     = 1,
  parameter int SATURATE = 0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up_down,
  input  logic             load,
  input  logic [WIDTH-1:0] data,
`ifdef COUNTER_OVF_STICKY_EN
  input  logic             clr_ovf,
  output logic             ovf_sticky,
`endif
  output logic [WIDTH-1:0] out,
  output logic             tc,
  output logic             wrap
);
  import counter_pkg::*;

  if ((WIDTH < 2) || (MAX_VAL < 1) || (clog2(MAX_VAL + 1) > WIDTH) ||
      (STEP < 1) || (STEP > MAX_VAL)) begin : g_bad_params
    $error("up_down_counter_param: illegal WIDTH/MAX_VAL/STEP combination");
  end

  localparam logic [WIDTH-1:0] MAX_N = WIDTH'(MAX_VAL);

  logic [WIDTH-1:0] nxt;
  logic             boundary;
  logic [WIDTH-1:0] load_val;
  logic             step_event;

  up_down_next #(
    .WIDTH    (WIDTH),
    .MAX_VAL  (MAX_VAL),
    .STEP     (STEP),
    .SATURATE (SATURATE)
  ) u_next (
    .cur      (out),
    .up_down  (up_down),
    .nxt      (nxt),
    .boundary (boundary)
  );

  // The step's boundary condition is exactly the terminal-count condition.
  assign tc = boundary;

  assign load_val   = (data > MAX_N) ? MAX_N : data;
  // Load pre-empts counting, so only an enabled, non-load edge can be an event.
  // In saturate mode a held boundary still reports boundary, so every
  // clamped attempt pulses wrap.
  assign step_event = en && !load && boundary;

  always_ff @(posedge clk) begin
    if (!reset) begin
      out  <= '0;
      wrap <= 1'b0;
    end else begin
      wrap <= step_event;
      if (load)    out <= load_val;
      else if (en) out <= nxt;
    end
  end

`ifdef COUNTER_OVF_STICKY_EN
  // Set wins over clear on the same edge.
  always_ff @(posedge clk) begin
    if (!reset) ovf_sticky <= 1'b0;
    else        ovf_sticky <= step_event || (ovf_sticky && !clr_ovf);
  end
`endif

endmodule

// File: tb/tb_up_down_counter_param.sv
// tb/tb_up_down_counter_param.sv - directed vector bench for up_down_counter_param
module tb_up_down_counter_param;

  logic       clk;
  logic       reset;
  logic       en;
  logic       up_down;
  logic       load;
  logic [3:0] data;
  logic       clr_ovf;

  logic [3:0] out0, out1, out2;
  logic       tc0, tc1, tc2;
  logic       wrap0, wrap1, wrap2;
  logic       ovf0;

  int vectors_applied;
  int miscompares;

  // d0: 0..9 step 1 wrap; d1: 0..9 step 3 wrap; d2: 0..9 step 3 saturate
  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(1), .SATURATE(0)) d0 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .data(data),
`ifdef COUNTER_OVF_STICKY_EN
    .clr_ovf(clr_ovf), .ovf_sticky(ovf0),
`endif
    .out(out0), .tc(tc0), .wrap(wrap0)
  );

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(0)) d1 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .data(data),
`ifdef COUNTER_OVF_STICKY_EN
    .clr_ovf(clr_ovf), .ovf_sticky(),
`endif
    .out(out1), .tc(tc1), .wrap(wrap1)
  );

  up_down_counter_param #(.WIDTH(4), .MAX_VAL(9), .STEP(3), .SATURATE(1)) d2 (
    .clk(clk), .reset(reset), .en(en), .up_down(up_down), .load(load), .data(data),
`ifdef COUNTER_OVF_STICKY_EN
    .clr_ovf(clr_ovf), .ovf_sticky(),
`endif
    .out(out2), .tc(tc2), .wrap(wrap2)
  );

`ifndef COUNTER_OVF_STICKY_EN
  assign ovf0 = 1'b0;
`endif

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       rst;
    logic       ld;
    logic       e;
    logic       ud;
    logic [3:0] d;
    int         dut;
    logic [3:0] exp_out;
    logic       exp_tc;
    logic       exp_wrap;
    string      name;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic rst, input logic ld, input logic e, input logic ud,
                     input logic [3:0] d, input int dut, input logic [3:0] eo,
                     input logic etc, input logic ew, input string name);
    vec_t v;
    v.rst = rst; v.ld = ld; v.e = e; v.ud = ud; v.d = d; v.dut = dut;
    v.exp_out = eo; v.exp_tc = etc; v.exp_wrap = ew; v.name = name;
    vecs.push_back(v);
  endtask

  task automatic drive(input logic rst, input logic ld, input logic e, input logic ud,
                       input logic [3:0] d, input logic clr);
    reset = rst; load = ld; en = e; up_down = ud; data = d; clr_ovf = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input int dut, input logic [3:0] eo, input logic etc,
                       input logic ew, input string name);
    logic [3:0] ao;
    logic       atc;
    logic       aw;
    case (dut)
      0:       begin ao = out0; atc = tc0; aw = wrap0; end
      1:       begin ao = out1; atc = tc1; aw = wrap1; end
      default: begin ao = out2; atc = tc2; aw = wrap2; end
    endcase
    vectors_applied++;
    if (ao !== eo || atc !== etc || aw !== ew) begin
      miscompares++;
      $display("FAIL %s (dut%0d): got out=%0d tc=%b wrap=%b, expected out=%0d tc=%b wrap=%b",
               name, dut, ao, atc, aw, eo, etc, ew);
    end
  endtask

  task automatic check_sticky(input logic exp, input string name);
    vectors_applied++;
    if (ovf0 !== exp) begin
      miscompares++;
      $display("FAIL %s: got ovf_sticky=%b, expected %b", name, ovf0, exp);
    end
  endtask

  initial begin
    vectors_applied = 0;
    miscompares     = 0;
    reset = 1'b0; load = 1'b0; en = 1'b0; up_down = 1'b1; data = '0; clr_ovf = 1'b0;

    // reset, then wrap-up on d0
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, "reset_1");
    add(0, 0, 0, 1, 0, 0, 0, 0, 0, "reset_2");
    for (int i = 1; i <= 9; i++)
      add(1, 0, 1, 1, 0, 0, 4'(i), (i == 9), 0, "up_count");
    add(1, 0, 1, 1, 0, 0, 0, 0, 1, "up_wrap_9_to_0");

    // down wrap with step 3 on d1
    add(1, 1, 0, 0, 2, 1, 2, 1, 0, "dn_load_2");
    add(1, 0, 1, 0, 0, 1, 9, 0, 1, "dn_wrap_2_to_9");
    add(1, 0, 1, 0, 0, 1, 6, 0, 0, "dn_6");
    add(1, 0, 1, 0, 0, 1, 3, 0, 0, "dn_3");
    add(1, 0, 1, 0, 0, 1, 0, 1, 0, "dn_0");
    add(1, 0, 1, 0, 0, 1, 7, 0, 1, "dn_wrap_0_to_7");

    // saturate mode on d2
    add(1, 1, 0, 1, 8, 2, 8, 1, 0, "sat_load_8");
    add(1, 0, 1, 1, 0, 2, 9, 1, 1, "sat_clamp_up");
    add(1, 0, 1, 1, 0, 2, 9, 1, 1, "sat_hold_9a");
    add(1, 0, 1, 1, 0, 2, 9, 1, 1, "sat_hold_9b");
    add(1, 0, 1, 0, 0, 2, 6, 0, 0, "sat_dn_6");
    add(1, 0, 1, 0, 0, 2, 3, 0, 0, "sat_dn_3");
    add(1, 0, 1, 0, 0, 2, 0, 1, 0, "sat_dn_0");
    add(1, 0, 1, 0, 0, 2, 0, 1, 1, "sat_hold_0a");
    add(1, 0, 1, 0, 0, 2, 0, 1, 1, "sat_hold_0b");

    // load clamp and priority on d0
    add(1, 1, 0, 1, 12, 0, 9, 1, 0, "load_clamp_12");
    add(1, 1, 1, 1, 4, 0, 4, 0, 0, "load_over_en");
    add(0, 1, 1, 1, 7, 0, 0, 0, 0, "reset_over_load");

    // enable hold after a wrap, then mid-run reset
    add(1, 1, 0, 1, 9, 0, 9, 1, 0, "load_9");
    add(1, 0, 1, 1, 0, 0, 0, 0, 1, "wrap_before_hold");
    for (int i = 0; i < 5; i++)
      add(1, 0, 0, 1, 0, 0, 0, 0, 0, "en0_hold");
    for (int i = 1; i <= 5; i++)
      add(1, 0, 1, 1, 0, 0, 4'(i), 0, 0, "count_to_5");
    add(1, 0, 1, 0, 0, 0, 4, 0, 0, "dir_change_down");
    add(1, 0, 1, 1, 0, 0, 5, 0, 0, "dir_change_up");
    add(0, 0, 1, 1, 0, 0, 0, 0, 0, "mid_run_reset");

    foreach (vecs[i]) begin
      drive(vecs[i].rst, vecs[i].ld, vecs[i].e, vecs[i].ud, vecs[i].d, 1'b0);
      check(vecs[i].dut, vecs[i].exp_out, vecs[i].exp_tc, vecs[i].exp_wrap, vecs[i].name);
    end

    // down count by 1 at zero on d0: wraps to MAX_VAL
    drive(1, 0, 1, 0, 0, 0);
    check(0, 9, 0, 1, "d0_dn_wrap_0_to_9");
    drive(1, 0, 0, 0, 0, 0);
    check(0, 9, 0, 0, "d0_wrap_clears");

`ifdef COUNTER_OVF_STICKY_EN
    drive(0, 0, 0, 1, 0, 0);
    check_sticky(1'b0, "sticky_reset");
    drive(1, 1, 0, 1, 9, 0);
    check_sticky(1'b0, "sticky_after_load");
    drive(1, 0, 1, 1, 0, 0);
    check_sticky(1'b1, "sticky_set_on_wrap");
    drive(1, 1, 0, 1, 3, 0);
    check_sticky(1'b1, "sticky_survives_load");
    drive(1, 0, 0, 1, 0, 0);
    check_sticky(1'b1, "sticky_holds");
    drive(1, 0, 0, 1, 0, 1);
    check_sticky(1'b0, "sticky_cleared");
    drive(1, 1, 0, 1, 9, 0);
    drive(1, 0, 1, 1, 0, 1);
    check_sticky(1'b1, "sticky_set_beats_clear");
    check(0, 0, 0, 1, "sticky_wrap_pulse");
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
    $finish;
  end

endmodule
